dual_port_ram: RTL
==================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, word width in bits; a multiple of 8.
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH words.
- RD_MODE, 0, cross-port read-during-write result: 0 = old data, 1 = new data.
- OUT_REG, 0, 1 = extra output pipeline register per port.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- en, in, 1, global clock enable; 0 freezes every register except under rst.
- ready, out, 1, high once the post-reset clear is complete.
- pN_req, in, 1, port N access request (N = 1, 2).
- pN_we, in, 1, 1 = write, 0 = read.
- pN_addr, in, ADDR_WIDTH, word address.
- pN_wdata, in, DATA_WIDTH, write data.
- pN_be, in, DATA_WIDTH/8, byte-lane write enables.
- pN_rdata, out, DATA_WIDTH, read data.
- pN_rvalid, out, 1, pN_rdata valid this cycle.
- collision, out, 1, one-cycle pulse: same-address dual write occurred.

Function
REQ-003 An access SHALL be accepted only in a cycle where en=1, ready=1 and pN_req=1.
- All other requests are ignored with no memory change.
REQ-004 FSM states SHALL be CLEAR and RUN.
- rst forces CLEAR with address counter = 0.
- CLEAR writes zero to word [counter] each en=1 cycle, then increments the counter.
- After the write to word 2^ADDR_WIDTH-1, the FSM enters RUN; ready rises in that same clock edge.
- RUN is held until rst.
REQ-005 Clear SHALL take exactly 2^ADDR_WIDTH en-high cycles; en=0 cycles pause it without losing progress.
REQ-006 An accepted write SHALL update only the byte lanes with pN_be=1; pN_be=0 leaves the word unchanged.
REQ-007 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from acceptance to pN_rvalid=1.
- pN_rvalid is high for exactly one en-high cycle per accepted read.
- Accepted writes never raise pN_rvalid.
REQ-008 pN_rdata SHALL hold its last value when pN_rvalid=0.
REQ-009 Reads SHALL be fully pipelined: one accepted read per port per cycle, with back-to-back results in order.
REQ-010 Simultaneous writes to the same address SHALL be resolved per byte lane:
- a lane with p1_be=1 takes p1_wdata;
- otherwise a lane with p2_be=1 takes p2_wdata;
- collision pulses high the next en-high cycle.
REQ-011 A simultaneous read on one port and write on the other to the same address SHALL return:
- the pre-write word when RD_MODE=0;
- the word merged with the write's enabled lanes when RD_MODE=1.
REQ-012 Different-address simultaneous accesses SHALL be independent; collision stays 0.
REQ-013 With en=0, memory, FSM, counter, pipeline registers, rdata, rvalid and collision SHALL all hold.
REQ-014 Address width SHALL be exact; no address wraps or aliases beyond 2^ADDR_WIDTH.

Reset
REQ-015 On rst=1, asynchronously:
- ready=0, pN_rvalid=0, pN_rdata=0, collision=0;
- pipeline valid bits cleared;
- FSM = CLEAR with counter = 0.
REQ-016 rst asserted mid-clear or mid-read SHALL restart the clear from address 0.
- In-flight reads are discarded and never produce rvalid.
REQ-017 Memory contents SHALL be all-zero whenever ready first rises after any reset.

Verification
REQ-018 The bench SHALL cover, with DATA_WIDTH=32 and ADDR_WIDTH=4 unless stated:
- Reset then en=1: ready rises after exactly 16 cycles; reading all 16 addresses returns 0x00000000.
- p1 writes 0xAABBCCDD to addr 3 with be=4'b0101, then p2 reads addr 3: rdata=0x00BB00DD, rvalid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
- Same cycle, p1 writes 0x11111111 with be=4'b0011 and p2 writes 0x22222222 with be=4'b1111, both to addr 5: the word becomes 0x22221111 and collision pulses once.
- Addr 7 holds 0x0; p1 writes 0xFFFFFFFF to addr 7 while p2 reads addr 7: p2_rdata=0x00000000 with RD_MODE=0, and 0xFFFFFFFF with RD_MODE=1.
- en=0 for 5 cycles during CLEAR and during a pending read: ready delay extends by 5 cycles; rvalid and rdata are frozen and resume unchanged.
- rst pulse 4 cycles into a read burst: no rvalid follows, ready drops, and the clear restarts at address 0.

Source files
------------

// File: rtl/dual_port_ram.sv
// True dual-port RAM with a post-reset zero-fill sequencer, per-lane write merging
// on same-address writes, selectable read-during-write behaviour and optional output register.
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    ready,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    p1_rvalid,
  input  logic                    p2_req,
  input  logic                    p2_we,
  input  logic [ADDR_WIDTH-1:0]   p2_addr,
  input  logic [DATA_WIDTH-1:0]   p2_wdata,
  input  logic [DATA_WIDTH/8-1:0] p2_be,
  output logic [DATA_WIDTH-1:0]   p2_rdata,
  output logic                    p2_rvalid,
  output logic                    collision
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [1:0]              s1_v_q;
  logic [DATA_WIDTH-1:0]   s1_d1_q, s1_d2_q;
  logic                    coll_q;
  logic                    p1_wr, p1_rd, p2_wr, p2_rd, same_addr;
  logic [DATA_WIDTH-1:0]   p1_rd_word, p2_rd_word;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [NB-1:0]         be);
    merge_lanes = old_w;
    for (int b = 0; b < NB; b++)
      if (be[b]) merge_lanes[b*8 +: 8] = new_w[b*8 +: 8];
  endfunction

  assign ready     = (state_q == RUN);
  assign p1_wr     = en & ready & p1_req & p1_we;
  assign p1_rd     = en & ready & p1_req & ~p1_we;
  assign p2_wr     = en & ready & p2_req & p2_we;
  assign p2_rd     = en & ready & p2_req & ~p2_we;
  assign same_addr = (p1_addr == p2_addr);
  assign collision = coll_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en && state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
    end
  end

  // New-data mode forwards the other port's enabled lanes into the read word.
  always_comb begin
    p1_rd_word = mem_q[p1_addr];
    p2_rd_word = mem_q[p2_addr];
    if (RD_MODE == 1 && same_addr) begin
      if (p2_wr) p1_rd_word = merge_lanes(mem_q[p1_addr], p2_wdata, p2_be);
      if (p1_wr) p2_rd_word = merge_lanes(mem_q[p2_addr], p1_wdata, p1_be);
    end
  end

  // Port 1 lanes are written last so they win on a same-address write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (state_q == CLEAR) mem_q[cnt_q] <= '0;
      for (int b = 0; b < NB; b++)
        if (p2_wr && p2_be[b]) mem_q[p2_addr][b*8 +: 8] <= p2_wdata[b*8 +: 8];
      for (int b = 0; b < NB; b++)
        if (p1_wr && p1_be[b]) mem_q[p1_addr][b*8 +: 8] <= p1_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      s1_v_q  <= '0;
      s1_d1_q <= '0;
      s1_d2_q <= '0;
      coll_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= {p2_rd, p1_rd};
      if (p1_rd) s1_d1_q <= p1_rd_word;
      if (p2_rd) s1_d2_q <= p2_rd_word;
      coll_q  <= p1_wr & p2_wr & same_addr;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [1:0]            s2_v_q;
    logic [DATA_WIDTH-1:0] s2_d1_q, s2_d2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_v_q  <= '0;
        s2_d1_q <= '0;
        s2_d2_q <= '0;
      end else if (en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q[0]) s2_d1_q <= s1_d1_q;
        if (s1_v_q[1]) s2_d2_q <= s1_d2_q;
      end
    end

    assign p1_rvalid = s2_v_q[0];
    assign p2_rvalid = s2_v_q[1];
    assign p1_rdata  = s2_d1_q;
    assign p2_rdata  = s2_d2_q;
  end else begin : g_out_direct
    assign p1_rvalid = s1_v_q[0];
    assign p2_rvalid = s1_v_q[1];
    assign p1_rdata  = s1_d1_q;
    assign p2_rdata  = s1_d2_q;
  end

endmodule
